// File: rtl/mixed_radix_counter.sv
// Cascaded multi-digit counter with a per-digit radix, up/down, load, wrap or saturate.
// The carry/borrow chain settles combinationally, so every digit updates on the same edge.
module mixed_radix_counter #(
    parameter int                        NUM_DIGITS  = 6,
    parameter logic [NUM_DIGITS*5-1:0]   DIGIT_BASES = {5'd6, 5'd10, 5'd6, 5'd10, 5'd10, 5'd10},
    parameter int                        DIGIT_W     = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            ena,
    input  logic                            dir,
    input  logic                            sat,
    input  logic                            load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   count_out,
    output logic                            at_zero,
    output logic                            at_max,
    output logic                            wrap_pulse,
    output logic                            done_pulse
);

    localparam int NW = NUM_DIGITS * DIGIT_W;

    logic [NW-1:0] count_q, count_d, step_cnt;
    logic          wrap_q, wrap_d, done_q, done_d;
    logic          at_max_c, at_zero_c, step_max, step_zero;
    logic          carry, limit_now, lands;
    logic [DIGIT_W-1:0] dig, ldig;

    function automatic logic [DIGIT_W-1:0] dmax(input int i);
        return DIGIT_W'(DIGIT_BASES[i*5 +: 5] - 5'd1);
    endfunction

    always_comb begin
        at_max_c  = 1'b1;
        at_zero_c = 1'b1;
        step_max  = 1'b1;
        step_zero = 1'b1;
        step_cnt  = count_q;
        carry     = 1'b1;
        dig       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_q[i*DIGIT_W +: DIGIT_W];
            if (dig != dmax(i)) at_max_c = 1'b0;
            if (dig != '0)      at_zero_c = 1'b0;
            // carry here means every lower digit sits at its roll-over value
            if (carry) begin
                if (!dir) begin
                    step_cnt[i*DIGIT_W +: DIGIT_W] = (dig == dmax(i)) ? '0 : dig + 1'b1;
                    carry = (dig == dmax(i));
                end else begin
                    step_cnt[i*DIGIT_W +: DIGIT_W] = (dig == '0) ? dmax(i) : dig - 1'b1;
                    carry = (dig == '0);
                end
            end
            if (step_cnt[i*DIGIT_W +: DIGIT_W] != dmax(i)) step_max = 1'b0;
            if (step_cnt[i*DIGIT_W +: DIGIT_W] != '0)      step_zero = 1'b0;
        end
    end

    assign limit_now = dir ? at_zero_c : at_max_c;
    assign lands     = dir ? step_zero : step_max;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        ldig    = '0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                ldig = load_val[i*DIGIT_W +: DIGIT_W];
                count_d[i*DIGIT_W +: DIGIT_W] = (ldig > dmax(i)) ? dmax(i) : ldig;
            end
        end else if (ena) begin
            if (limit_now) begin
                if (!sat) begin
                    count_d = step_cnt;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = step_cnt;
                done_d  = sat && lands;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count_out  = count_q;
    assign at_zero    = at_zero_c;
    assign at_max     = at_max_c;
    assign wrap_pulse = wrap_q;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_mixed_radix_counter.sv
// Directed bench for mixed_radix_counter: MM:SS.cc default build plus a 2-digit {16,2} build.
module tb_mixed_radix_counter;

    logic        clk = 1'b0;
    logic        rst_n, clr, ena, dir, sat, load;
    logic [23:0] load_val, count_out;
    logic        at_zero, at_max, wrap_pulse, done_pulse;

    logic        clr2, ena2, dir2, sat2, load2;
    logic [7:0]  load_val2, count_out2;
    logic        at_zero2, at_max2, wrap_pulse2, done_pulse2;

    int n_chk = 0;
    int n_err = 0;
    int n_done, n_wrap;

    always #5 clk = ~clk;

    mixed_radix_counter dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ena(ena), .dir(dir), .sat(sat),
        .load(load), .load_val(load_val), .count_out(count_out), .at_zero(at_zero),
        .at_max(at_max), .wrap_pulse(wrap_pulse), .done_pulse(done_pulse)
    );

    mixed_radix_counter #(
        .NUM_DIGITS(2), .DIGIT_BASES({5'd16, 5'd2}), .DIGIT_W(4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .ena(ena2), .dir(dir2), .sat(sat2),
        .load(load2), .load_val(load_val2), .count_out(count_out2), .at_zero(at_zero2),
        .at_max(at_max2), .wrap_pulse(wrap_pulse2), .done_pulse(done_pulse2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [23:0] v);
        load = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic step(input logic d, input logic s);
        dir = d;
        sat = s;
        ena = 1'b1;
        tick();
        ena = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; ena = 1'b0; dir = 1'b0; sat = 1'b0; load = 1'b0;
        load_val = '0;
        clr2 = 1'b0; ena2 = 1'b0; dir2 = 1'b0; sat2 = 1'b0; load2 = 1'b0; load_val2 = '0;
        #2 rst_n = 1'b1;
        tick();
        chk("reset_count", count_out, 24'h000000);
        chk("reset_at_zero", at_zero, 1'b1);
        chk("reset_at_max", at_max, 1'b0);
        chk("reset_pulses", {wrap_pulse, done_pulse}, 2'b00);

        do_load(24'h123456);
        chk("load_123456", count_out, 24'h123456);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count_out, 24'h000000);
        chk("async_rst_at_zero", at_zero, 1'b1);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk("first_tick", count_out, 24'h000001);

        do_load(24'h095999);
        step(1'b0, 1'b0);
        chk("carry_ripple", count_out, 24'h100000);
        chk("carry_no_wrap", wrap_pulse, 1'b0);
        do_load(24'h595999);
        chk("at_max_after_load", at_max, 1'b1);
        step(1'b0, 1'b0);
        chk("up_wrap_count", count_out, 24'h000000);
        chk("up_wrap_pulse", wrap_pulse, 1'b1);
        chk("up_wrap_at_zero", at_zero, 1'b1);
        tick();
        chk("up_wrap_pulse_clears", wrap_pulse, 1'b0);

        do_load(24'h100000);
        step(1'b1, 1'b0);
        chk("borrow_ripple", count_out, 24'h095999);
        chk("borrow_no_wrap", wrap_pulse, 1'b0);
        do_load(24'h000000);
        step(1'b1, 1'b0);
        chk("down_wrap_count", count_out, 24'h595999);
        chk("down_wrap_pulse", wrap_pulse, 1'b1);
        chk("down_wrap_at_max", at_max, 1'b1);

        do_load(24'h000003);
        n_done = 0;
        n_wrap = 0;
        dir = 1'b1; sat = 1'b1; ena = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("sat_cnt_%0d", k), count_out, (k < 3) ? 24'(3 - k) : 24'h0);
            chk($sformatf("sat_done_%0d", k), done_pulse, (k == 3) ? 1'b1 : 1'b0);
            n_done += int'(done_pulse);
            n_wrap += int'(wrap_pulse);
        end
        ena = 1'b0;
        chk("sat_done_once", n_done, 1);
        chk("sat_never_wrap", n_wrap, 0);
        step(1'b0, 1'b1);
        chk("sat_leave_limit", count_out, 24'h000001);
        chk("sat_leave_no_done", done_pulse, 1'b0);

        clr = 1'b1; load = 1'b1; load_val = 24'h123456; ena = 1'b1;
        tick();
        clr = 1'b0; load = 1'b0; ena = 1'b0;
        chk("clr_beats_load", count_out, 24'h000000);
        load = 1'b1; load_val = 24'h00F000; ena = 1'b1; dir = 1'b0;
        tick();
        load = 1'b0; ena = 1'b0;
        chk("load_clamp_no_inc", count_out, 24'h005000);
        do_load(24'hFFFFFF);
        chk("load_clamp_all", count_out, 24'h595999);
        step(1'b0, 1'b1);
        chk("sat_up_hold", count_out, 24'h595999);
        chk("sat_up_no_pulses", {wrap_pulse, done_pulse}, 2'b00);
        for (int k = 0; k < 10; k++) begin
            dir = k[0];
            sat = k[1];
            load_val = 24'(k);
            tick();
        end
        chk("idle_hold", count_out, 24'h595999);

        ena2 = 1'b1;
        n_wrap = 0;
        for (int k = 1; k <= 33; k++) begin
            tick();
            chk($sformatf("sweep_val_%0d", k),
                {24'h0, count_out2[7:4], 1'b0} + {31'h0, count_out2[0]}, k % 32);
            chk($sformatf("sweep_d0_range_%0d", k), count_out2[3:1], 3'b000);
            chk($sformatf("sweep_wrap_%0d", k), wrap_pulse2, (k == 32) ? 1'b1 : 1'b0);
            n_wrap += int'(wrap_pulse2);
        end
        ena2 = 1'b0;
        chk("sweep_wrap_once", n_wrap, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mixed_radix_counter.md
Name: mixed_radix_counter

Overview:
- Parametrised multi-digit cascaded counter. Each digit has its own radix; digit 0 is least significant.
- Generalises the single-digit base-N counter with up/down counting, parallel load, wrap or saturate mode, and terminal flags.
- Drives the 6-digit MM:SS.cc timer/stopwatch datapath directly. Replaces chains of single-digit counters and their one-cycle-per-stage carry delay.

Parameters:
- NUM_DIGITS, 6: number of digits, 1..8.
- DIGIT_BASES, {5'd6,5'd10,5'd6,5'd10,5'd10,5'd10}: packed NUM_DIGITS×5 bits, digit 0 in the LSBs. Each radix is 2..16. Default is the MM:SS.cc timer.
- DIGIT_W, 4: output bits per digit. Must satisfy 2^DIGIT_W >= largest base.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of all digits to 0.
- ena  input  1  count tick; one step per cycle while high.
- dir  input  1  0 = count up, 1 = count down.
- sat  input  1  0 = wrap at limits, 1 = saturate (hold) at limits.
- load  input  1  synchronous parallel load.
- load_val  input  NUM_DIGITS×DIGIT_W  value to load, digit 0 in the LSBs.
- count_out  output  NUM_DIGITS×DIGIT_W  current count, digit 0 in the LSBs.
- at_zero  output  1  high when all digits are 0.
- at_max  output  1  high when every digit equals its base−1.
- wrap_pulse  output  1  one-cycle pulse: the counter wrapped (max→0 going up, 0→max going down).
- done_pulse  output  1  one-cycle pulse: saturate mode reached its limit.

Behaviour:
- Async reset (rst_n low): count_out=0, wrap_pulse=0, done_pulse=0. Hence at_zero=1, at_max=0. Takes effect immediately, mid-count included. After rst_n rises, the first clock edge with ena=1 counts; no dead cycle.
- Priority per rising edge: clr > load > ena. With none asserted, the count holds. clr and load clear both pulses.
- Load: each digit gets load_val[i], clamped to DIGIT_BASES[i]−1 if out of range. The load_val of an empty digit slot is ignored beyond DIGIT_W bits.
- Up step (dir=0):
  - Digit i increments when all lower digits equal base−1. It wraps to 0 when it is itself at base−1.
  - The full carry chain resolves combinationally within one cycle. New count_out is visible the cycle after the ena edge, with no per-digit skew.
- Down step (dir=1):
  - Digit i decrements when all lower digits are 0. It wraps to base−1 from 0.
- Wrap mode (sat=0), ena while at_max with dir=0 (or at_zero with dir=1):
  - count rolls to 0 (or to all base−1).
  - wrap_pulse=1 for exactly the following cycle.
- Saturate mode (sat=1), ena while at the limit in the count direction:
  - count holds and wrap_pulse stays 0.
  - done_pulse=1 for one cycle, only on the step that lands on the limit (e.g. 00:00.01→00:00.00 down). Not repeated while ena stays high at the limit.
  - A step that moves away from the limit (dir flipped) proceeds normally.
- at_zero and at_max are combinational decodes of the registered count. They add no latency and are glitch-free relative to clk.
- Pulses are registered and assert in the cycle after the causing edge. They deassert the next cycle unless re-caused (e.g. continuous wrapping with a single digit of base 2).
- dir, sat and load_val are sampled only on edges where they are used. Changing them between ticks has no effect.
- Widths: all digit arithmetic is done in DIGIT_W bits. No digit value ≥ its base ever appears on count_out.

Test Plan:
- Reset/first tick: assert rst_n=0 mid-count at 12:34.56 → count_out=0 and at_zero=1 asynchronously. Release, ena=1, dir=0 for one edge → count 00:00.01.
- Up carry ripple: load 09:59.99, sat=0, one ena up → 10:00.00 in one cycle; wrap_pulse=0. Load 59:59.99, one ena up → 00:00.00, wrap_pulse=1 for one cycle, at_zero=1.
- Down borrow: load 10:00.00, dir=1, one ena → 09:59.99. From 00:00.00 with sat=0 → 59:59.99, wrap_pulse=1, at_max=1.
- Saturate countdown: load 00:00.03, sat=1, dir=1, ena held 6 cycles → 02, 01, 00, then holds at 00. done_pulse high exactly once (cycle after reaching 00); wrap_pulse never asserts.
- Priority/clamp: clr=1, load=1, ena=1 same edge → 0. load=1 with ena=1 and load_val digit3=0xF → digit3=5, no increment that cycle. ena=0 for 10 cycles → count unchanged.
- Parameter sweep: NUM_DIGITS=2, DIGIT_BASES={16,2}, free-run up 33 ticks → sequence 0..31 then 0, 1. wrap_pulse once, after tick 32.
